mem_port_arbiter: RTL and testbench

//  Shares the single memory port between the cpu instruction-fetch (I) and load/store (D) requesters.
//  One transaction is outstanding at a time. The arbiter grants a requester, forwards its request to

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_pick.sv | 36 +++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the memory port arbiter.
//   state_t : arbiter FSM states (ST_IDLE, ST_WAIT)
//   owner_t : requester identity (OWN_I = instruction fetch, OWN_D = load/store)
package mem_arb_pkg;

   localparam int unsigned AW_DEF      = 32;
   localparam int unsigned DW_DEF      = 32;
   localparam int unsigned TIMEOUT_DEF = 255;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

endpackage : mem_arb_pkg

// File: rtl/arb_pick.sv
// arb_pick: combinational winner selection between fetch (I) and data (D) requests.
//   i_req, d_req : pending requests
//   last         : requester granted most recently
//   win          : selected requester (meaningful only when a request is present)
// Build option ARB_ROUND_ROBIN_EN: on contention grant the requester other than last.
// Without it, D always wins contention. Single requests are granted the same way in both builds.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic   i_req,
   input  logic   d_req,
   input  owner_t last,
   output owner_t win
);

`ifndef ARB_ROUND_ROBIN_EN
   // last only matters for the round-robin build
   logic unused_last;
   assign unused_last = ^last;
`endif

   // Winner selection
   always_comb begin
      win = OWN_I;
      if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
         win = (last == OWN_I) ? OWN_D : OWN_I;
`else
         win = OWN_D;
`endif
      end else if (d_req) begin
         win = OWN_D;
      end
   end

endmodule : arb_pick

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (I) and load/store (D).
// One transaction is outstanding at a time; a watchdog aborts accesses that never get a response.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   i_req/i_addr -> i_gnt/i_rvalid/i_rdata          fetch requester
//   d_req/d_we/d_be/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata   data requester
//   err                               1-cycle pulse on watchdog abort
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata        memory request (valid in grant cycle only)
//   mem_rvalid/mem_rdata              memory response (read data or write ack)
// Grants and response routing are combinational by design so a grant and its memory strobe
// share a cycle, and a response reaches its owner in the cycle it arrives.
// Build option ARB_ROUND_ROBIN_EN (see arb_pick) selects round-robin instead of fixed D priority.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW      = AW_DEF,
   parameter int unsigned DW      = DW_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic            i_gnt,
   output logic            i_rvalid,
   output logic [DW-1:0]   i_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [DW/8-1:0] d_be,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   output logic            d_gnt,
   output logic            d_rvalid,
   output logic [DW-1:0]   d_rdata,
   output logic            err,
   output logic            mem_req,
   output logic            mem_we,
   output logic [DW/8-1:0] mem_be,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   input  logic            mem_rvalid,
   input  logic [DW-1:0]   mem_rdata
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   state_t        state_q, state_d;
   owner_t        owner_q, owner_d;
   owner_t        last_q,  last_d;
   logic [TW-1:0] tcnt_q,  tcnt_d;
   owner_t        win;

   arb_pick u_pick (
      .i_req (i_req),
      .d_req (d_req),
      .last  (last_q),
      .win   (win)
   );

   // Next state, grants, request forwarding and response routing
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      tcnt_d    = tcnt_q;
      i_gnt     = 1'b0;
      d_gnt     = 1'b0;
      i_rvalid  = 1'b0;
      d_rvalid  = 1'b0;
      i_rdata   = '0;
      d_rdata   = '0;
      err       = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_be    = '0;
      mem_addr  = '0;
      mem_wdata = '0;

      // Outputs stay quiet while reset is held, even though they are combinational
      if (!rst) begin
         unique case (state_q)
            ST_IDLE: begin
               // Responses arriving in IDLE are stale and deliberately dropped
               if (i_req || d_req) begin
                  state_d = ST_WAIT;
                  owner_d = win;
                  last_d  = win;
                  tcnt_d  = '0;
                  mem_req = 1'b1;
                  if (win == OWN_D) begin
                     d_gnt     = 1'b1;
                     mem_we    = d_we;
                     mem_be    = d_be;
                     mem_addr  = d_addr;
                     mem_wdata = d_wdata;
                  end else begin
                     i_gnt    = 1'b1;
                     mem_be   = '1;
                     mem_addr = i_addr;
                  end
               end
            end
            ST_WAIT: begin
               // tcnt counts completed silent WAIT cycles; the abort fires in the
               // TIMEOUT-th WAIT cycle, and a real response in that cycle still wins
               if (mem_rvalid || (tcnt_q == TW'(TIMEOUT - 1))) begin
                  state_d = ST_IDLE;
                  err     = !mem_rvalid;
                  if (owner_q == OWN_D) begin
                     d_rvalid = 1'b1;
                     d_rdata  = mem_rvalid ? mem_rdata : '0;
                  end else begin
                     i_rvalid = 1'b1;
                     i_rdata  = mem_rvalid ? mem_rdata : '0;
                  end
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_I;
         last_q  <= OWN_I;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         tcnt_q  <= tcnt_d;
      end
   end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a
// transaction-level reference model (busy/owner/last/waited-cycles).
module tb_mem_port_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = DW / 8;
   localparam int          TO = 4;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_gnt, i_rvalid;
   logic [DW-1:0] i_rdata;
   logic          d_req, d_we;
   logic [BW-1:0] d_be;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_gnt, d_rvalid;
   logic [DW-1:0] d_rdata;
   logic          err, mem_req, mem_we;
   logic [BW-1:0] mem_be;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_rvalid;
   logic [DW-1:0] mem_rdata;

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .err(err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   // Reference model: is a transaction open, who owns it, who won last, silent cycles so far
   bit m_busy = 0, m_own = 0, m_last = 0;
   int m_waited = 0;

   // Expected and observed outputs of the most recent cycle
   logic          e_i_gnt, e_d_gnt, e_i_rv, e_d_rv, e_err, e_mreq, e_we;
   logic [BW-1:0] e_be;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata, e_i_rdata, e_d_rdata;
   logic          o_i_gnt, o_d_gnt, o_i_rv, o_d_rv, o_err, o_mreq, o_we;
   logic [BW-1:0] o_be;
   logic [DW-1:0] o_wdata, o_i_rdata, o_d_rdata;

   // Memory responder: latency in cycles after the request, 0 = never respond
   int            mem_lat = 1;
   int            pend = 0;
   bit            rand_data = 1;
   logic [DW-1:0] mem_data = '0;
   bit            keep_i = 0, keep_d = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock cycle: predict and check at negedge, advance model and stimulus after posedge
   task automatic cycle();
      bit n_busy, n_own, n_last, w;
      int n_waited;
      @(negedge clk);
      {e_i_gnt, e_d_gnt, e_i_rv, e_d_rv, e_err, e_mreq, e_we} = '0;
      e_be = '0; e_addr = '0; e_wdata = '0; e_i_rdata = '0; e_d_rdata = '0;
      n_busy = m_busy; n_own = m_own; n_last = m_last; n_waited = m_waited;
      if (rst) begin
         n_busy = 0; n_own = 0; n_last = 0; n_waited = 0;
      end else if (!m_busy) begin
         if (i_req || d_req) begin
            w = (i_req && d_req) ? (RR ? !m_last : 1'b1) : d_req;
            e_mreq = 1; n_busy = 1; n_own = w; n_last = w; n_waited = 0;
            if (w) begin
               e_d_gnt = 1; e_we = d_we; e_be = d_be; e_addr = d_addr; e_wdata = d_wdata;
            end else begin
               e_i_gnt = 1; e_be = '1; e_addr = i_addr;
            end
         end
      end else begin
         if (mem_rvalid || (m_waited + 1 == TO)) begin
            if (m_own) begin e_d_rv = 1; e_d_rdata = mem_rvalid ? mem_rdata : '0; end
            else       begin e_i_rv = 1; e_i_rdata = mem_rvalid ? mem_rdata : '0; end
            e_err  = !mem_rvalid;
            n_busy = 0;
         end else begin
            n_waited = m_waited + 1;
         end
      end
      chk("i_gnt",     64'(i_gnt),     64'(e_i_gnt));
      chk("d_gnt",     64'(d_gnt),     64'(e_d_gnt));
      chk("i_rvalid",  64'(i_rvalid),  64'(e_i_rv));
      chk("d_rvalid",  64'(d_rvalid),  64'(e_d_rv));
      chk("i_rdata",   64'(i_rdata),   64'(e_i_rdata));
      chk("d_rdata",   64'(d_rdata),   64'(e_d_rdata));
      chk("err",       64'(err),       64'(e_err));
      chk("mem_req",   64'(mem_req),   64'(e_mreq));
      chk("mem_we",    64'(mem_we),    64'(e_we));
      chk("mem_be",    64'(mem_be),    64'(e_be));
      chk("mem_addr",  64'(mem_addr),  64'(e_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
      o_i_gnt = i_gnt; o_d_gnt = d_gnt; o_i_rv = i_rvalid; o_d_rv = d_rvalid; o_err = err;
      o_mreq = mem_req; o_we = mem_we; o_be = mem_be; o_wdata = mem_wdata;
      o_i_rdata = i_rdata; o_d_rdata = d_rdata;
      @(posedge clk);
      m_busy = n_busy; m_own = n_own; m_last = n_last; m_waited = n_waited;
      #1;
      if (e_mreq && mem_lat > 0) pend = mem_lat;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rand_data ? DW'($urandom) : mem_data;
         end
      end
      if (e_i_gnt && !keep_i) i_req = 1'b0;
      if (e_d_gnt && !keep_d) d_req = 1'b0;
   endtask

   initial begin
      bit exp_seq [4];
      int k;
      rst = 1; i_req = 1; i_addr = '0;
      d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
      mem_rvalid = 0; mem_rdata = '0;

      // Reset held 3 cycles with a pending fetch: nothing granted
      for (int c = 0; c < 3; c++) begin
         cycle();
         chk("rst_no_gnt", 64'(o_i_gnt), 64'd0);
      end
      rst = 0; mem_lat = 1;
      cycle();
      chk("first_i_gnt", 64'(o_i_gnt), 64'd1);
      cycle();
      chk("first_i_rvalid", 64'(o_i_rv), 64'd1);

      // Load with latency 2 and known data
      d_req = 1; d_we = 0; d_addr = 32'h100; d_be = 4'hF;
      mem_lat = 2; rand_data = 0; mem_data = 32'hDEAD_BEEF;
      cycle();
      chk("load_gnt", 64'(o_d_gnt), 64'd1);
      cycle();
      chk("load_n1_rvalid", 64'(o_d_rv), 64'd0);
      cycle();
      chk("load_rvalid", 64'(o_d_rv), 64'd1);
      chk("load_rdata", 64'(o_d_rdata), 64'h0000_0000_DEAD_BEEF);
      chk("load_i_rvalid", 64'(o_i_rv), 64'd0);
      rand_data = 1;

      // Contention from a fresh reset, both requests held for 4 transactions
      rst = 1; cycle(); rst = 0;
      exp_seq = RR ? '{1'b1, 1'b0, 1'b1, 1'b0} : '{1'b1, 1'b1, 1'b1, 1'b1};
      keep_i = 1; keep_d = 1; i_req = 1; d_req = 1; mem_lat = 1; k = 0;
      for (int c = 0; c < 8; c++) begin
         cycle();
         if ((o_i_gnt || o_d_gnt) && k < 4) begin
            chk("contention_winner", 64'(o_d_gnt), 64'(exp_seq[k]));
            k++;
         end
      end
      chk("contention_grants", 64'(k), 64'd4);
      keep_i = 0; keep_d = 0; i_req = 0; d_req = 0;
      cycle();

      // Store forwarding and ack
      d_req = 1; d_we = 1; d_be = 4'b0011; d_wdata = 32'h1234_5678; d_addr = 32'h200;
      mem_lat = 1;
      cycle();
      chk("store_we", 64'(o_we), 64'd1);
      chk("store_be", 64'(o_be), 64'h3);
      chk("store_wdata", 64'(o_wdata), 64'h1234_5678);
      cycle();
      chk("store_ack", 64'(o_d_rv), 64'd1);
      d_we = 0;

      // Timeout: memory never answers
      i_req = 1; i_addr = 32'h40; mem_lat = 0;
      cycle();
      chk("to_gnt", 64'(o_i_gnt), 64'd1);
      for (int c = 0; c < 3; c++) begin
         cycle();
         chk("to_no_err_yet", 64'(o_err), 64'd0);
      end
      cycle();
      chk("to_err", 64'(o_err), 64'd1);
      chk("to_i_rvalid", 64'(o_i_rv), 64'd1);
      chk("to_i_rdata", 64'(o_i_rdata), 64'd0);
      mem_rvalid = 1; mem_rdata = 32'hAAAA_5555;
      cycle();
      chk("stale_i_rvalid", 64'(o_i_rv), 64'd0);
      chk("stale_d_rvalid", 64'(o_d_rv), 64'd0);

      // Reset during WAIT drops the transaction
      i_req = 1; i_addr = 32'h80; mem_lat = 0;
      cycle();
      cycle();
      rst = 1; cycle(); rst = 0;
      mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
      cycle();
      chk("rstwait_i_rvalid", 64'(o_i_rv), 64'd0);
      chk("rstwait_d_rvalid", 64'(o_d_rv), 64'd0);
      i_req = 1; mem_lat = 1;
      cycle();
      chk("rstwait_regrant", 64'(o_i_gnt), 64'd1);
      cycle();
      chk("rstwait_resp", 64'(o_i_rv), 64'd1);

      // Randomized traffic: latencies 1..5 (5 exceeds the watchdog), occasional resets
      for (int c = 0; c < 400; c++) begin
         if (!i_req && $urandom_range(0, 2) == 0) begin
            i_req = 1; i_addr = $urandom;
         end
         if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1; d_we = 1'($urandom); d_be = BW'($urandom);
            d_addr = $urandom; d_wdata = $urandom;
         end
         rst = ($urandom_range(0, 63) == 0);
         mem_lat = $urandom_range(1, 5);
         cycle();
      end
      rst = 0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_mem_port_arbiter
